// File: rtl/alveo_rst_seq_pkg.sv
// Shared types and helpers for the Alveo reset sequencer.
package alveo_rst_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_MMCM_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_IDLY_RST  = 3'd2,
    ST_WAIT_RDY  = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } seq_state_e;

  // Bits needed to hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/alveo_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module alveo_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/alveo_rst_sequencer.sv
// Board clocking reset sequencer on the free-running clk_100 reference.
// Define RST_SEQ_IDELAY_EN to add the IDELAYCTRL reset/ready stage with retry and fail states.
module alveo_rst_sequencer
  import alveo_rst_seq_pkg::*;
#(
  parameter int MMCM_RST_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int IDLY_RST_CYCLES    = 8,
  parameter int RDY_TIMEOUT        = 4096,
  parameter int MAX_RETRIES        = 3,
  parameter int N_DOMAINS          = 4,
  parameter int STAGGER_CYCLES     = 16
) (
  input  logic                               clk_100,
  input  logic                               rst_n,
  input  logic                               pll_lock,
  input  logic                               idelay_rdy,
  input  logic                               soft_rst_req,
  output logic                               mmcm_rst,
  output logic                               idelay_rst,
  output logic [N_DOMAINS-1:0]               dom_rst,
  output logic                               seq_done,
  output logic                               seq_fail,
  output logic [STATE_W-1:0]                 state_dbg,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

  // One shared counter, sized for the longest interval any state measures.
  localparam int REL_CYCLES = STAGGER_CYCLES * N_DOMAINS;
  localparam int TOP_A      = (MMCM_RST_CYCLES > LOCK_STABLE_CYCLES) ? MMCM_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int TOP_B      = (IDLY_RST_CYCLES > RDY_TIMEOUT) ? IDLY_RST_CYCLES : RDY_TIMEOUT;
  localparam int TOP_C      = (TOP_A > TOP_B) ? TOP_A : TOP_B;
  localparam int CNT_TOP    = (TOP_C > REL_CYCLES) ? TOP_C : REL_CYCLES;
  localparam int CNT_W      = cnt_width(CNT_TOP);

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_TOP);
  localparam logic [CNT_W-1:0] MMCM_LAST = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_END   = CNT_W'(REL_CYCLES);

  seq_state_e           state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
  logic                 lock_s;
  logic                 mmcm_rst_nxt, seq_done_nxt;
  logic [N_DOMAINS-1:0] dom_rst_nxt;

  alveo_sync_2ff u_sync_lock (.clk(clk_100), .rst_n(rst_n), .d(pll_lock), .q(lock_s));

`ifdef RST_SEQ_IDELAY_EN
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] IDLY_LAST = CNT_W'(IDLY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RDY_LAST  = CNT_W'(RDY_TIMEOUT - 1);

  logic               rdy_s;
  logic [RETRY_W-1:0] retry_q, retry_nxt;
  logic               idelay_rst_nxt, seq_fail_nxt;

  alveo_sync_2ff u_sync_rdy (.clk(clk_100), .rst_n(rst_n), .d(idelay_rdy), .q(rdy_s));
  assign retry_cnt = retry_q;
`else
  logic unused_rdy;
  assign unused_rdy = idelay_rdy;
  assign idelay_rst = 1'b0;
  assign seq_fail   = 1'b0;
  assign retry_cnt  = '0;
`endif

  assign cnt_inc   = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
  assign state_dbg = state;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_MMCM_RST;
      cnt      <= '0;
      mmcm_rst <= 1'b1;
      dom_rst  <= '1;
      seq_done <= 1'b0;
`ifdef RST_SEQ_IDELAY_EN
      retry_q    <= '0;
      idelay_rst <= 1'b1;
      seq_fail   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mmcm_rst <= mmcm_rst_nxt;
      dom_rst  <= dom_rst_nxt;
      seq_done <= seq_done_nxt;
`ifdef RST_SEQ_IDELAY_EN
      retry_q    <= retry_nxt;
      idelay_rst <= idelay_rst_nxt;
      seq_fail   <= seq_fail_nxt;
`endif
    end
  end

  // Soft request beats lock loss, which beats ready and timeout.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_inc;
`ifdef RST_SEQ_IDELAY_EN
    retry_nxt = retry_q;
`endif
    if (soft_rst_req) begin
      state_nxt = ST_MMCM_RST;
      cnt_nxt   = '0;
`ifdef RST_SEQ_IDELAY_EN
      retry_nxt = '0;
`endif
    end else begin
      case (state)
        ST_MMCM_RST: begin
          if (cnt == MMCM_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_nxt = '0;
          end else if (cnt == LOCK_LAST) begin
`ifdef RST_SEQ_IDELAY_EN
            state_nxt = ST_IDLY_RST;
`else
            state_nxt = ST_RELEASE;
`endif
            cnt_nxt   = '0;
          end
        end
`ifdef RST_SEQ_IDELAY_EN
        ST_IDLY_RST: begin
          if (!lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == IDLY_LAST) begin
            state_nxt = ST_WAIT_RDY;
            cnt_nxt   = '0;
          end
        end
        ST_WAIT_RDY: begin
          if (!lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (rdy_s) begin
            state_nxt = ST_RELEASE;
            cnt_nxt   = '0;
          end else if (cnt == RDY_LAST) begin
            cnt_nxt = '0;
            if (retry_q < RETRY_W'(MAX_RETRIES)) begin
              retry_nxt = retry_q + 1'b1;
              state_nxt = ST_MMCM_RST;
            end else begin
              state_nxt = ST_FAIL;
            end
          end
        end
        ST_FAIL: cnt_nxt = cnt;
`endif
        ST_RELEASE: begin
          if (!lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt_inc == REL_END) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end
        ST_RUN: begin
          cnt_nxt = cnt;
`ifdef RST_SEQ_IDELAY_EN
          retry_nxt = '0;
`endif
          if (!lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_MMCM_RST;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    mmcm_rst_nxt = 1'b0;
    dom_rst_nxt  = '1;
    seq_done_nxt = 1'b0;
`ifdef RST_SEQ_IDELAY_EN
    idelay_rst_nxt = 1'b0;
    seq_fail_nxt   = 1'b0;
`endif
    case (state_nxt)
      ST_MMCM_RST: begin
        mmcm_rst_nxt = 1'b1;
`ifdef RST_SEQ_IDELAY_EN
        idelay_rst_nxt = 1'b1;
`endif
      end
`ifdef RST_SEQ_IDELAY_EN
      ST_WAIT_LOCK: idelay_rst_nxt = 1'b1;
      ST_IDLY_RST:  idelay_rst_nxt = 1'b1;
      ST_FAIL: begin
        mmcm_rst_nxt   = 1'b1;
        idelay_rst_nxt = 1'b1;
        seq_fail_nxt   = 1'b1;
      end
`endif
      ST_RELEASE: begin
        for (int i = 0; i < N_DOMAINS; i++) begin
          dom_rst_nxt[i] = (cnt_nxt < CNT_W'(STAGGER_CYCLES * (i + 1)));
        end
      end
      ST_RUN: begin
        dom_rst_nxt  = '0;
        seq_done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alveo_rst_sequencer.sv
// Directed bench for alveo_rst_sequencer; covers both RST_SEQ_IDELAY_EN builds.
module tb_alveo_rst_sequencer;

  localparam int N_DOM = 4;

`ifdef RST_SEQ_IDELAY_EN
  localparam logic       IDLY_EXP   = 1'b1;
  localparam logic [2:0] AFTER_LOCK = 3'd2;
`else
  localparam logic       IDLY_EXP   = 1'b0;
  localparam logic [2:0] AFTER_LOCK = 3'd4;
`endif

  logic             clk_100 = 1'b0;
  logic             rst_n = 1'b0;
  logic             pll_lock = 1'b0;
  logic             idelay_rdy = 1'b0;
  logic             soft_rst_req = 1'b0;
  logic             mmcm_rst, idelay_rst, seq_done, seq_fail;
  logic [N_DOM-1:0] dom_rst;
  logic [2:0]       state_dbg;
  logic [1:0]       retry_cnt;

  int total = 0;
  int bad = 0;

  // clock / reset
  always #5 clk_100 = ~clk_100;

  alveo_rst_sequencer #(
    .MMCM_RST_CYCLES(16), .LOCK_STABLE_CYCLES(8), .IDLY_RST_CYCLES(8), .RDY_TIMEOUT(32),
    .MAX_RETRIES(2), .N_DOMAINS(N_DOM), .STAGGER_CYCLES(4)
  ) dut (
    .clk_100(clk_100), .rst_n(rst_n), .pll_lock(pll_lock), .idelay_rdy(idelay_rdy),
    .soft_rst_req(soft_rst_req), .mmcm_rst(mmcm_rst), .idelay_rst(idelay_rst),
    .dom_rst(dom_rst), .seq_done(seq_done), .seq_fail(seq_fail),
    .state_dbg(state_dbg), .retry_cnt(retry_cnt)
  );

`ifndef RST_SEQ_IDELAY_EN
  logic idly_seen = 1'b0, odd_state_seen = 1'b0, fail_seen = 1'b0;
  always @(negedge clk_100) begin
    if (idelay_rst !== 1'b0) idly_seen = 1'b1;
    if (state_dbg === 3'd2 || state_dbg === 3'd3 || state_dbg === 3'd6) odd_state_seen = 1'b1;
    if (seq_fail !== 1'b0 || retry_cnt !== 2'd0) fail_seen = 1'b1;
  end
`endif

  // driver tasks
  task automatic apply_reset(input logic lock, input logic rdy);
    rst_n = 1'b0;
    soft_rst_req = 1'b0;
    pll_lock = lock;
    idelay_rdy = rdy;
    repeat (3) @(negedge clk_100);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk_100);
      if (state_dbg === st) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic bring_up_run(output int n);
    apply_reset(1'b1, 1'b1);
    wait_state(3'd5, 150, n);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    pll_lock = 1'b0;
    idelay_rdy = 1'b0;
    soft_rst_req = 1'b0;
    repeat (3) @(negedge clk_100);
    total++; if (mmcm_rst !== 1'b1) begin bad++; $display("FAIL reset_mmcm_rst got=%b exp=1", mmcm_rst); end
    total++; if (idelay_rst !== IDLY_EXP) begin bad++; $display("FAIL reset_idelay_rst got=%b exp=%b", idelay_rst, IDLY_EXP); end
    total++; if (dom_rst !== 4'hF) begin bad++; $display("FAIL reset_dom_rst got=%h exp=f", dom_rst); end
    total++; if (seq_done !== 1'b0 || seq_fail !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", seq_done, seq_fail); end
    total++; if (state_dbg !== 3'd0 || retry_cnt !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d/%0d exp=0/0", state_dbg, retry_cnt); end
    rst_n = 1'b1;
    pll_lock = 1'b1;
    wait_state(3'd1, 40, n);
    total++; if (n !== 16) begin bad++; $display("FAIL reset_to_wait_lock got=%0d exp=16", n); end
    @(posedge clk_100);
    #2 rst_n = 1'b0;
    #1;
    total++; if (state_dbg !== 3'd0 || mmcm_rst !== 1'b1 || dom_rst !== 4'hF) begin
      bad++; $display("FAIL reset_async got=st%0d mmcm%b dom%h exp=st0 mmcm1 domf", state_dbg, mmcm_rst, dom_rst);
    end
  endtask

  task automatic test_nominal();
    int n;
    int fall[N_DOM];
    apply_reset(1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 40 && mmcm_rst === 1'b1; i++) begin
      n++;
      @(negedge clk_100);
    end
    total++; if (n !== 16) begin bad++; $display("FAIL nominal_mmcm_width got=%0d exp=16", n); end
    total++; if (state_dbg !== 3'd1) begin bad++; $display("FAIL nominal_wait_lock got=%0d exp=1", state_dbg); end
    repeat (3) @(negedge clk_100);
    pll_lock = 1'b1;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_100);
      if (state_dbg !== 3'd1) begin n = i; break; end
    end
    total++; if (n !== 10) begin bad++; $display("FAIL nominal_lock_latency got=%0d exp=10", n); end
`ifdef RST_SEQ_IDELAY_EN
    total++; if (state_dbg !== 3'd2) begin bad++; $display("FAIL nominal_idly_state got=%0d exp=2", state_dbg); end
    n = 0;
    for (int i = 0; i < 40 && idelay_rst === 1'b1; i++) begin
      n++;
      @(negedge clk_100);
    end
    total++; if (n !== 8) begin bad++; $display("FAIL nominal_idly_width got=%0d exp=8", n); end
    repeat (4) @(negedge clk_100);
    total++; if (state_dbg !== 3'd3) begin bad++; $display("FAIL nominal_wait_rdy got=%0d exp=3", state_dbg); end
    idelay_rdy = 1'b1;
    wait_state(3'd4, 20, n);
    total++; if (n !== 3) begin bad++; $display("FAIL nominal_rdy_latency got=%0d exp=3", n); end
`else
    total++; if (state_dbg !== 3'd4) begin bad++; $display("FAIL nominal_direct_release got=%0d exp=4", state_dbg); end
`endif
    total++; if (dom_rst !== 4'hF) begin bad++; $display("FAIL nominal_release_entry got=%h exp=f", dom_rst); end
    for (int i = 0; i < N_DOM; i++) fall[i] = -1;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk_100);
      for (int i = 0; i < N_DOM; i++) if (fall[i] < 0 && dom_rst[i] === 1'b0) fall[i] = j;
      if (state_dbg === 3'd5) break;
    end
    for (int i = 0; i < N_DOM; i++) begin
      total++; if (fall[i] !== 4 * (i + 1)) begin bad++; $display("FAIL nominal_dom_fall[%0d] got=%0d exp=%0d", i, fall[i], 4 * (i + 1)); end
    end
    total++; if (state_dbg !== 3'd5 || seq_done !== 1'b1) begin bad++; $display("FAIL nominal_run got=st%0d done%b exp=st5 done1", state_dbg, seq_done); end
    total++; if (retry_cnt !== 2'd0 || seq_fail !== 1'b0) begin bad++; $display("FAIL nominal_no_retry got=%0d/%b exp=0/0", retry_cnt, seq_fail); end
  endtask

  task automatic test_lock_glitch();
    int n;
    apply_reset(1'b0, 1'b0);
    wait_state(3'd1, 40, n);
    total++; if (n < 0) begin bad++; $display("FAIL glitch_reach_wait_lock got=%0d exp=16", n); end
    pll_lock = 1'b1;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_100);
      if (state_dbg !== 3'd1) begin n = i; break; end
      if (i == 6) pll_lock = 1'b0;
      if (i == 7) pll_lock = 1'b1;
    end
    total++; if (n !== 17) begin bad++; $display("FAIL glitch_restart got=%0d exp=17", n); end
    total++; if (state_dbg !== AFTER_LOCK) begin bad++; $display("FAIL glitch_next_state got=%0d exp=%0d", state_dbg, AFTER_LOCK); end
  endtask

`ifdef RST_SEQ_IDELAY_EN
  task automatic test_retries();
    int n;
    apply_reset(1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      wait_state(3'd3, 80, n);
      total++; if (n < 0) begin bad++; $display("FAIL retry_reach_wait_rdy[%0d] got=%0d exp=>0", k, n); end
      n = 0;
      for (int i = 0; i < 60 && state_dbg === 3'd3; i++) begin
        n++;
        @(negedge clk_100);
      end
      total++; if (n !== 32) begin bad++; $display("FAIL retry_timeout_len[%0d] got=%0d exp=32", k, n); end
      if (k < 3) begin
        total++; if (state_dbg !== 3'd0 || retry_cnt !== 2'(k)) begin
          bad++; $display("FAIL retry_step[%0d] got=st%0d r%0d exp=st0 r%0d", k, state_dbg, retry_cnt, k);
        end
      end
    end
    total++; if (state_dbg !== 3'd6 || seq_fail !== 1'b1 || retry_cnt !== 2'd2) begin
      bad++; $display("FAIL retry_fail got=st%0d f%b r%0d exp=st6 f1 r2", state_dbg, seq_fail, retry_cnt);
    end
    total++; if (mmcm_rst !== 1'b1 || idelay_rst !== 1'b1 || dom_rst !== 4'hF) begin
      bad++; $display("FAIL retry_fail_resets got=%b%b%h exp=11f", mmcm_rst, idelay_rst, dom_rst);
    end
    repeat (8) @(negedge clk_100);
    total++; if (state_dbg !== 3'd6) begin bad++; $display("FAIL retry_fail_hold got=%0d exp=6", state_dbg); end
    soft_rst_req = 1'b1;
    @(negedge clk_100);
    soft_rst_req = 1'b0;
    total++; if (state_dbg !== 3'd0 || mmcm_rst !== 1'b1 || retry_cnt !== 2'd0 || seq_fail !== 1'b0) begin
      bad++; $display("FAIL retry_soft_exit got=st%0d m%b r%0d f%b exp=st0 m1 r0 f0", state_dbg, mmcm_rst, retry_cnt, seq_fail);
    end
    wait_state(3'd3, 80, n);
    wait_state(3'd0, 60, n);
    total++; if (retry_cnt !== 2'd1) begin bad++; $display("FAIL retry_again got=%0d exp=1", retry_cnt); end
    wait_state(3'd3, 80, n);
    pll_lock = 1'b0;
    repeat (3) @(negedge clk_100);
    total++; if (state_dbg !== 3'd1 || retry_cnt !== 2'd1) begin
      bad++; $display("FAIL retry_lock_loss got=st%0d r%0d exp=st1 r1", state_dbg, retry_cnt);
    end
    pll_lock = 1'b1;
  endtask
`endif

  task automatic test_lock_loss();
    int n;
    bring_up_run(n);
    total++; if (n < 0) begin bad++; $display("FAIL lockloss_reach_run got=%0d exp=>0", n); end
    pll_lock = 1'b0;
    repeat (2) @(negedge clk_100);
    total++; if (dom_rst !== 4'h0 || seq_done !== 1'b1) begin bad++; $display("FAIL lockloss_early got=%h/%b exp=0/1", dom_rst, seq_done); end
    @(negedge clk_100);
    total++; if (dom_rst !== 4'hF || seq_done !== 1'b0) begin bad++; $display("FAIL lockloss_resets got=%h/%b exp=f/0", dom_rst, seq_done); end
    total++; if (state_dbg !== 3'd1 || retry_cnt !== 2'd0 || mmcm_rst !== 1'b0) begin
      bad++; $display("FAIL lockloss_state got=st%0d r%0d m%b exp=st1 r0 m0", state_dbg, retry_cnt, mmcm_rst);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    bring_up_run(n);
    total++; if (n < 0) begin bad++; $display("FAIL simul_reach_run got=%0d exp=>0", n); end
    pll_lock = 1'b0;
    repeat (2) @(negedge clk_100);
    soft_rst_req = 1'b1;
    @(negedge clk_100);
    soft_rst_req = 1'b0;
    total++; if (state_dbg !== 3'd0 || mmcm_rst !== 1'b1 || dom_rst !== 4'hF) begin
      bad++; $display("FAIL simul_priority got=st%0d m%b d%h exp=st0 m1 df", state_dbg, mmcm_rst, dom_rst);
    end
  endtask

  task automatic test_soft_req();
    int n;
    bring_up_run(n);
    total++; if (n < 0) begin bad++; $display("FAIL soft_reach_run got=%0d exp=>0", n); end
    soft_rst_req = 1'b1;
    @(negedge clk_100);
    soft_rst_req = 1'b0;
    total++; if (state_dbg !== 3'd0 || mmcm_rst !== 1'b1 || seq_done !== 1'b0 || dom_rst !== 4'hF) begin
      bad++; $display("FAIL soft_restart got=st%0d m%b s%b d%h exp=st0 m1 s0 df", state_dbg, mmcm_rst, seq_done, dom_rst);
    end
  endtask

`ifndef RST_SEQ_IDELAY_EN
  task automatic test_macro_off();
    total++; if (idly_seen !== 1'b0) begin bad++; $display("FAIL off_idelay_rst got=%b exp=0", idly_seen); end
    total++; if (odd_state_seen !== 1'b0) begin bad++; $display("FAIL off_state_set got=%b exp=0", odd_state_seen); end
    total++; if (fail_seen !== 1'b0) begin bad++; $display("FAIL off_fail_retry got=%b exp=0", fail_seen); end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_lock_glitch();
`ifdef RST_SEQ_IDELAY_EN
    test_retries();
`endif
    test_lock_loss();
    test_simultaneous();
    test_soft_req();
`ifndef RST_SEQ_IDELAY_EN
    test_macro_off();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
